// File: rtl/led_seq_pkg.sv
// Shared encodings and helpers for the LED mode sequencer.
// Mode, command opcode and bounce-direction types live here so the top, the step logic and the bench agree.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_UP     = 2'd0,
        MODE_DOWN   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        OP_SET_MODE    = 2'd0,
        OP_LOAD        = 2'd1,
        OP_HOLD_TOGGLE = 2'd2,
        OP_CLEAR       = 2'd3
    } op_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    // Auto rotation never enters or leaves HOLD; HOLD maps to itself.
    function automatic mode_e next_mode_auto(input mode_e m);
        case (m)
            MODE_UP:     return MODE_DOWN;
            MODE_DOWN:   return MODE_BOUNCE;
            MODE_BOUNCE: return MODE_UP;
            default:     return MODE_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/led_mode_sequencer_if.sv
// Command handshake bundle between the button/PMOD front end (master) and the sequencer (slave).
interface led_mode_sequencer_if
    import led_seq_pkg::*;
#(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    op_e              cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_ready;

    modport master (output cmd_valid, output cmd_op, output cmd_data, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_op, input  cmd_data, output cmd_ready);
endinterface

// File: rtl/led_mode_sequencer_led_step.sv
// Combinational per-tick LED update for the current mode.
// Bounce walks a single lit LED and reflects at either end, flagging wrap when it lands back on bit 0.
module led_step
    import led_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  mode_e            mode_i,
    input  logic [WIDTH-1:0] led_i,
    input  dir_e             dir_i,
    output logic [WIDTH-1:0] led_o,
    output dir_e             dir_o,
    output logic             wrap_o
);
    localparam logic [WIDTH-1:0] LED_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] LED_MSB = LED_ONE << (WIDTH - 1);
    localparam logic [WIDTH-1:0] LED_ALL = '1;

    logic             one_hot;
    dir_e             eff_dir;
    logic [WIDTH-1:0] shifted;

    assign one_hot = (led_i != '0) && ((led_i & (led_i - LED_ONE)) == '0);

    // A lit LED sitting on an end always moves inward, even if a LOAD left the direction stale.
    always_comb begin
        eff_dir = dir_i;
        if (led_i == LED_MSB) begin
            eff_dir = DIR_RIGHT;
        end else if (led_i == LED_ONE) begin
            eff_dir = DIR_LEFT;
        end
    end

    assign shifted = (eff_dir == DIR_LEFT) ? (led_i << 1) : (led_i >> 1);

    always_comb begin
        led_o  = led_i;
        dir_o  = dir_i;
        wrap_o = 1'b0;
        case (mode_i)
            MODE_UP: begin
                led_o  = led_i + LED_ONE;
                wrap_o = (led_i == LED_ALL);
            end
            MODE_DOWN: begin
                led_o  = led_i - LED_ONE;
                wrap_o = (led_i == '0);
            end
            MODE_BOUNCE: begin
                if (one_hot) begin
                    led_o = shifted;
                    dir_o = eff_dir;
                    if (shifted == LED_MSB) begin
                        dir_o = DIR_RIGHT;
                    end else if (shifted == LED_ONE) begin
                        dir_o  = DIR_LEFT;
                        wrap_o = 1'b1;
                    end
                end else begin
                    led_o = LED_ONE;
                    dir_o = DIR_LEFT;
                end
            end
            default: begin
                led_o = led_i;
            end
        endcase
    end

endmodule

// File: rtl/led_mode_sequencer.sv
// LED mode sequencer: command handshake, mode FSM, auto-rotation dwell counter and registered LED outputs.
// Each accepted command is followed by one apply cycle in which nothing steps and cmd_ready is low.
module led_mode_sequencer
    import led_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DWELL = 8
) (
    input  logic                 clock_out,
    input  logic                 rst,
    led_mode_sequencer_if.slave  cmd,
    input  logic                 auto_en,
    output logic [WIDTH-1:0]     led,
    output logic [1:0]           mode,
    output logic                 wrap
);
    localparam int              DW         = $clog2(DWELL) + 1;
    localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
    localparam logic [WIDTH-1:0] LED_ONE   = WIDTH'(1);

    mode_e            mode_q;
    mode_e            saved_q;
    dir_e             dir_q;
    logic [WIDTH-1:0] led_q;
    logic             wrap_q;
    logic             ready_q;
    logic [DW-1:0]    dwell_q;

    logic [WIDTH-1:0] step_led_d;
    dir_e             step_dir_d;
    logic             step_wrap_d;
    logic             auto_active;
    logic             advance_due;
    mode_e            auto_mode_d;

    led_step #(.WIDTH(WIDTH)) u_step (
        .mode_i (mode_q),
        .led_i  (led_q),
        .dir_i  (dir_q),
        .led_o  (step_led_d),
        .dir_o  (step_dir_d),
        .wrap_o (step_wrap_d)
    );

    assign auto_active = auto_en && (mode_q != MODE_HOLD);
    assign advance_due = auto_active && (dwell_q == DWELL_LAST);
    assign auto_mode_d = next_mode_auto(mode_q);

    // Priority per edge: apply cycle, then an accepted command, then a due auto advance, then a normal step.
    always_ff @(posedge clock_out or posedge rst) begin
        if (rst) begin
            mode_q  <= MODE_UP;
            saved_q <= MODE_UP;
            dir_q   <= DIR_LEFT;
            led_q   <= '0;
            wrap_q  <= 1'b0;
            ready_q <= 1'b1;
            dwell_q <= '0;
        end else begin
            wrap_q <= 1'b0;
            if (!ready_q) begin
                ready_q <= 1'b1;
            end else if (cmd.cmd_valid) begin
                ready_q <= 1'b0;
                dwell_q <= '0;
                case (cmd.cmd_op)
                    OP_SET_MODE: begin
                        mode_q <= mode_e'(cmd.cmd_data[1:0]);
                        if (mode_e'(cmd.cmd_data[1:0]) == MODE_BOUNCE) begin
                            led_q <= LED_ONE;
                            dir_q <= DIR_LEFT;
                        end
                    end
                    OP_LOAD: begin
                        led_q <= cmd.cmd_data;
                    end
                    OP_HOLD_TOGGLE: begin
                        if (mode_q != MODE_HOLD) begin
                            saved_q <= mode_q;
                            mode_q  <= MODE_HOLD;
                        end else begin
                            mode_q <= saved_q;
                        end
                    end
                    OP_CLEAR: begin
                        led_q  <= '0;
                        mode_q <= MODE_UP;
                        dir_q  <= DIR_LEFT;
                    end
                    default: begin
                        led_q <= led_q;
                    end
                endcase
            end else if (advance_due) begin
                mode_q  <= auto_mode_d;
                dwell_q <= '0;
                if (auto_mode_d == MODE_BOUNCE) begin
                    led_q <= LED_ONE;
                    dir_q <= DIR_LEFT;
                end
            end else begin
                led_q  <= step_led_d;
                dir_q  <= step_dir_d;
                wrap_q <= step_wrap_d;
                if (auto_active) begin
                    dwell_q <= dwell_q + 1'b1;
                end
            end
        end
    end

    assign led           = led_q;
    assign mode          = mode_q;
    assign wrap          = wrap_q;
    assign cmd.cmd_ready = ready_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Directed bench for led_mode_sequencer (WIDTH=4, DWELL=3): one task per scenario, hand-computed expectations.
module tb_led_mode_sequencer;
    import led_seq_pkg::*;

    logic       clock_out;
    logic       rst;
    logic       autoEn;
    logic [3:0] led;
    logic [1:0] mode;
    logic       wrap;

    int nChecks = 0;
    int nPass   = 0;

    led_mode_sequencer_if #(.WIDTH(4)) cmdIf ();

    led_mode_sequencer #(.WIDTH(4), .DWELL(3)) dut (
        .clock_out (clock_out),
        .rst       (rst),
        .cmd       (cmdIf),
        .auto_en   (autoEn),
        .led       (led),
        .mode      (mode),
        .wrap      (wrap)
    );

    initial clock_out = 1'b0;
    always #5 clock_out = ~clock_out;

    task automatic tick();
        @(posedge clock_out);
        #1;
    endtask

    task automatic drive(input op_e op, input logic [3:0] data);
        cmdIf.cmd_valid = 1'b1;
        cmdIf.cmd_op    = op;
        cmdIf.cmd_data  = data;
    endtask

    // Accept edge followed by the apply edge.
    task automatic sendCmd(input op_e op, input logic [3:0] data);
        drive(op, data);
        tick();
        cmdIf.cmd_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        nChecks++; if (led !== 4'h0) $display("[TB] FAIL reset_led: got %0h expected 0", led); else nPass++;
        nChecks++; if (mode !== 2'd0) $display("[TB] FAIL reset_mode: got %0d expected 0", mode); else nPass++;
        nChecks++; if (cmdIf.cmd_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %0b expected 1", cmdIf.cmd_ready); else nPass++;
        nChecks++; if (wrap !== 1'b0) $display("[TB] FAIL reset_wrap: got %0b expected 0", wrap); else nPass++;
    endtask

    task automatic test_count_up();
        logic [3:0] expLed;
        for (int i = 0; i < 17; i++) begin
            tick();
            expLed = 4'((i + 1) % 16);
            nChecks++; if (led !== expLed) $display("[TB] FAIL up_led[%0d]: got %0h expected %0h", i, led, expLed); else nPass++;
            nChecks++; if (wrap !== (i == 15)) $display("[TB] FAIL up_wrap[%0d]: got %0b expected %0b", i, wrap, (i == 15)); else nPass++;
        end
    endtask

    task automatic test_load_down();
        logic [3:0] expSeq [4] = '{4'h2, 4'h1, 4'h0, 4'hF};
        drive(OP_LOAD, 4'h3);
        tick();
        nChecks++; if (cmdIf.cmd_ready !== 1'b0) $display("[TB] FAIL load_ready_low: got %0b expected 0", cmdIf.cmd_ready); else nPass++;
        nChecks++; if (led !== 4'h3) $display("[TB] FAIL load_led: got %0h expected 3", led); else nPass++;
        cmdIf.cmd_data = 4'h7;
        tick();
        cmdIf.cmd_valid = 1'b0;
        nChecks++; if (cmdIf.cmd_ready !== 1'b1) $display("[TB] FAIL load_ready_back: got %0b expected 1", cmdIf.cmd_ready); else nPass++;
        nChecks++; if (led !== 4'h3) $display("[TB] FAIL apply_ignore_led: got %0h expected 3", led); else nPass++;
        drive(OP_SET_MODE, 4'h1);
        tick();
        cmdIf.cmd_valid = 1'b0;
        nChecks++; if (cmdIf.cmd_ready !== 1'b0) $display("[TB] FAIL setdown_ready_low: got %0b expected 0", cmdIf.cmd_ready); else nPass++;
        nChecks++; if (mode !== 2'd1) $display("[TB] FAIL setdown_mode: got %0d expected 1", mode); else nPass++;
        tick();
        nChecks++; if (led !== 4'h3) $display("[TB] FAIL setdown_apply_led: got %0h expected 3", led); else nPass++;
        for (int i = 0; i < 4; i++) begin
            tick();
            nChecks++; if (led !== expSeq[i]) $display("[TB] FAIL down_led[%0d]: got %0h expected %0h", i, led, expSeq[i]); else nPass++;
            nChecks++; if (wrap !== (i == 3)) $display("[TB] FAIL down_wrap[%0d]: got %0b expected %0b", i, wrap, (i == 3)); else nPass++;
        end
    endtask

    task automatic test_bounce();
        logic [3:0] expSeq [7] = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
        sendCmd(OP_SET_MODE, 4'h2);
        nChecks++; if (led !== 4'h1) $display("[TB] FAIL bounce_entry_led: got %0h expected 1", led); else nPass++;
        nChecks++; if (mode !== 2'd2) $display("[TB] FAIL bounce_mode: got %0d expected 2", mode); else nPass++;
        for (int i = 0; i < 7; i++) begin
            tick();
            nChecks++; if (led !== expSeq[i]) $display("[TB] FAIL bounce_led[%0d]: got %0h expected %0h", i, led, expSeq[i]); else nPass++;
            nChecks++; if (wrap !== (i == 5)) $display("[TB] FAIL bounce_wrap[%0d]: got %0b expected %0b", i, wrap, (i == 5)); else nPass++;
        end
    endtask

    task automatic test_hold();
        sendCmd(OP_LOAD, 4'h5);
        sendCmd(OP_SET_MODE, 4'h0);
        sendCmd(OP_HOLD_TOGGLE, 4'h0);
        nChecks++; if (mode !== 2'd3) $display("[TB] FAIL hold_mode: got %0d expected 3", mode); else nPass++;
        for (int i = 0; i < 4; i++) begin
            tick();
            nChecks++; if (led !== 4'h5) $display("[TB] FAIL hold_led[%0d]: got %0h expected 5", i, led); else nPass++;
        end
        sendCmd(OP_HOLD_TOGGLE, 4'h0);
        nChecks++; if (mode !== 2'd0) $display("[TB] FAIL unhold_mode: got %0d expected 0", mode); else nPass++;
        nChecks++; if (led !== 4'h5) $display("[TB] FAIL unhold_led: got %0h expected 5", led); else nPass++;
        tick();
        nChecks++; if (led !== 4'h6) $display("[TB] FAIL resume_led0: got %0h expected 6", led); else nPass++;
        tick();
        nChecks++; if (led !== 4'h7) $display("[TB] FAIL resume_led1: got %0h expected 7", led); else nPass++;
    endtask

    task automatic test_auto();
        logic [1:0] expMode [11] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0};
        logic [3:0] expLed  [11] = '{4'h1, 4'h2, 4'h2, 4'h1, 4'h0, 4'h1, 4'h2, 4'h4, 4'h4, 4'h5, 4'h6};
        rst = 1'b1;
        #2;
        rst = 1'b0;
        autoEn = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            nChecks++; if (mode !== expMode[i]) $display("[TB] FAIL auto_mode[%0d]: got %0d expected %0d", i, mode, expMode[i]); else nPass++;
            nChecks++; if (led !== expLed[i]) $display("[TB] FAIL auto_led[%0d]: got %0h expected %0h", i, led, expLed[i]); else nPass++;
        end
        drive(OP_CLEAR, 4'h0);
        tick();
        cmdIf.cmd_valid = 1'b0;
        nChecks++; if (mode !== 2'd0) $display("[TB] FAIL clear_mode: got %0d expected 0", mode); else nPass++;
        nChecks++; if (led !== 4'h0) $display("[TB] FAIL clear_led: got %0h expected 0", led); else nPass++;
        tick();
        tick();
        nChecks++; if (mode !== 2'd0 || led !== 4'h1) $display("[TB] FAIL clear_dwell0: got mode %0d led %0h expected mode 0 led 1", mode, led); else nPass++;
        tick();
        nChecks++; if (mode !== 2'd0 || led !== 4'h2) $display("[TB] FAIL clear_dwell1: got mode %0d led %0h expected mode 0 led 2", mode, led); else nPass++;
        tick();
        nChecks++; if (mode !== 2'd1 || led !== 4'h2) $display("[TB] FAIL clear_advance: got mode %0d led %0h expected mode 1 led 2", mode, led); else nPass++;
        autoEn = 1'b0;
    endtask

    task automatic test_reset_apply();
        drive(OP_LOAD, 4'hA);
        tick();
        cmdIf.cmd_valid = 1'b0;
        nChecks++; if (led !== 4'hA) $display("[TB] FAIL rstapply_load: got %0h expected a", led); else nPass++;
        rst = 1'b1;
        #1;
        nChecks++; if (led !== 4'h0) $display("[TB] FAIL rstapply_led: got %0h expected 0", led); else nPass++;
        nChecks++; if (cmdIf.cmd_ready !== 1'b1) $display("[TB] FAIL rstapply_ready: got %0b expected 1", cmdIf.cmd_ready); else nPass++;
        nChecks++; if (mode !== 2'd0) $display("[TB] FAIL rstapply_mode: got %0d expected 0", mode); else nPass++;
        #1;
        rst = 1'b0;
        tick();
        nChecks++; if (led !== 4'h1) $display("[TB] FAIL rstapply_first_tick: got %0h expected 1", led); else nPass++;
    endtask

    initial begin
        rst             = 1'b1;
        autoEn          = 1'b0;
        cmdIf.cmd_valid = 1'b0;
        cmdIf.cmd_op    = OP_SET_MODE;
        cmdIf.cmd_data  = 4'h0;
        #12;
        rst = 1'b0;
        test_reset();
        test_count_up();
        test_load_down();
        test_bounce();
        test_hold();
        test_auto();
        test_reset_apply();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/led_mode_sequencer.md
Name: led_mode_sequencer

Overview:
- Controller that sequences the on-board LED datapath at the 1 Hz tick rate.
- Selects among count-up, count-down, bounce (single lit LED sweeping) and hold modes.
- Accepts commands over a valid/ready handshake from the button/PMOD front end.
- Optional auto mode rotates through modes on a fixed dwell.

Parameters:
- WIDTH, 4, LED vector width (min 2)
- DWELL, 8, ticks spent in each mode when auto_en=1 (min 1)

Ports:
- clock_out  in  1  sequencer clock, one edge per 1 Hz tick
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_op  in  2  0=SET_MODE, 1=LOAD, 2=HOLD_TOGGLE, 3=CLEAR
- cmd_data  in  WIDTH  SET_MODE: [1:0] new mode; LOAD: new led value; else ignored
- cmd_ready  out  1  command may be accepted this cycle
- auto_en  in  1  enable automatic mode rotation
- led  out  WIDTH  LED drive value, registered
- mode  out  2  current mode: 0=UP, 1=DOWN, 2=BOUNCE, 3=HOLD
- wrap  out  1  one-cycle pulse on sequence wrap

Behaviour:
- Clock is clock_out; reset rst is asynchronous and active-high.
- Reset values: led=0, mode=UP, cmd_ready=1, wrap=0, dwell counter=0, bounce direction=left, saved mode=UP.
- Handshake: a command is accepted on an edge with cmd_valid=1 and cmd_ready=1.
  - On that same edge the command is applied and cmd_ready goes to 0 for exactly one cycle (apply cycle), then returns to 1.
  - cmd_valid while cmd_ready=0 is ignored; no queueing.
- Per-tick step, on a non-apply, non-command cycle:
  - UP: led+1 mod 2^WIDTH. wrap=1 on the edge producing all-ones to 0.
  - DOWN: led-1 mod 2^WIDTH. wrap=1 on the edge producing 0 to all-ones.
  - BOUNCE, led one-hot: shift toward the current direction.
    - On reaching MSB, direction becomes right.
    - On reaching bit0, direction becomes left and wrap=1.
  - BOUNCE, led not one-hot (including 0): next led=1, direction=left, no wrap.
  - HOLD: led unchanged.
- During the apply cycle, led holds and wrap=0.
- Commands:
  - SET_MODE: mode=cmd_data[1:0]. Entering BOUNCE forces led=1, direction=left. Other modes keep led.
  - LOAD: led=cmd_data; mode unchanged.
  - HOLD_TOGGLE: if mode!=HOLD, save mode and set mode=HOLD; else restore the saved mode.
  - CLEAR: led=0, mode=UP, direction=left.
  - Every command clears the dwell counter.
- Auto rotation:
  - With auto_en=1 and mode!=HOLD, dwell increments each step cycle.
  - When dwell reaches DWELL-1, the next step cycle advances mode UP->DOWN->BOUNCE->UP, dwell=0, and applies BOUNCE entry rules.
  - The mode advance replaces the led step on that edge.
  - auto_en=0 freezes dwell at its value.
  - A command accepted on the same edge as a due advance wins; the advance is discarded and dwell=0.
- Reset mid-operation, including during the apply cycle, returns all state to reset values immediately.
- All arithmetic is WIDTH bits, modular; dwell counter width is clog2(DWELL)+1.

Decomposition:
- Package led_seq_pkg:
  - mode encodings MODE_UP/DOWN/BOUNCE/HOLD
  - op encodings OP_SET_MODE/LOAD/HOLD_TOGGLE/CLEAR
  - next_mode_auto function
- Sub-module led_step: combinational.
  - Inputs: mode, led, dir.
  - Outputs: next led, next dir, wrap.
- Top holds the FSM, handshake and dwell counter.

Test Plan:
- Reset, mode UP, 17 ticks -> led 0,1,...,15,0,1; wrap high only on the 15->0 edge.
- LOAD 4'h3 then SET_MODE DOWN -> cmd_ready low one cycle after each accept; led 3,3(apply),2,1,0,F with wrap on 0->F.
- SET_MODE BOUNCE -> led 1,2,4,8,4,2,1,2; wrap pulses on the 2->1 edge.
- HOLD_TOGGLE in UP at led=5 -> led stays 5 for 4 ticks; second HOLD_TOGGLE resumes UP: 5,6,7.
- auto_en=1, DWELL=3, start UP -> modes UP,UP,UP,DOWN,...; BOUNCE entry forces led=1. A CLEAR on the due-advance edge -> mode UP, led 0, dwell 0.
- Assert rst during the apply cycle after LOAD 4'hA -> led=0, cmd_ready=1, mode=UP asynchronously; first tick after release -> led=1.
